// File: rtl/fetch_stall_stage.sv
// Fetch-side pipeline state owner.
// Holds the PC, the IF/ID register and the control half of ID/EX, applies
// hazard-unit hold/bubble requests and branch redirects, and keeps
// saturating stall/flush performance counters.
module fetch_stall_stage #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter int unsigned          CTRL_WIDTH  = 9,
    parameter int unsigned          CNT_WIDTH   = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PCwrite,
    input  logic                   IFIDwrite,
    input  logic                   controlmux,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic [CTRL_WIDTH-1:0]  id_ctrl,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic [INSTR_WIDTH-1:0] ifid_instr,
    output logic                   ifid_valid,
    output logic [CTRL_WIDTH-1:0]  idex_ctrl,
    output logic                   idex_valid,
    output logic [CNT_WIDTH-1:0]   stall_cycles,
    output logic [CNT_WIDTH-1:0]   flush_cycles
);

    logic [PC_WIDTH-1:0]    pc_q,         pc_d;
    logic [PC_WIDTH-1:0]    ifid_pc_q,    ifid_pc_d;
    logic [INSTR_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [CTRL_WIDTH-1:0]  idex_ctrl_q,  idex_ctrl_d;
    logic                   idex_valid_q, idex_valid_d;
    logic [CNT_WIDTH-1:0]   stall_q,      stall_d;
    logic [CNT_WIDTH-1:0]   flush_q,      flush_d;

    // Next-state: redirect beats hold for PC and IF/ID; bubble ID/EX on any kill source.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        idex_ctrl_d  = id_ctrl;
        idex_valid_d = 1'b1;
        stall_d      = stall_q;
        flush_d      = flush_q;

        if (branch_taken) begin
            pc_d = {branch_target[PC_WIDTH-1:2], 2'b00};
        end else if (!PCwrite) begin
            pc_d = pc_q + PC_WIDTH'(4);
        end

        if (branch_taken) begin
            ifid_pc_d    = '0;
            ifid_instr_d = '0;
            ifid_valid_d = 1'b0;
        end else if (!IFIDwrite) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_instr;
            ifid_valid_d = 1'b1;
        end

        if (controlmux || branch_taken || !ifid_valid_q) begin
            idex_ctrl_d  = '0;
            idex_valid_d = 1'b0;
        end

        if (PCwrite && !branch_taken && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
        if (branch_taken && (flush_q != '1)) begin
            flush_d = flush_q + CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset that overrides every request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
            idex_valid_q <= 1'b0;
            stall_q      <= '0;
            flush_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            idex_ctrl_q  <= idex_ctrl_d;
            idex_valid_q <= idex_valid_d;
            stall_q      <= stall_d;
            flush_q      <= flush_d;
        end
    end

    assign pc           = pc_q;
    assign ifid_pc      = ifid_pc_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_valid   = ifid_valid_q;
    assign idex_ctrl    = idex_ctrl_q;
    assign idex_valid   = idex_valid_q;
    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;

endmodule

// File: tb/tb_fetch_stall_stage.sv
// Bench for fetch_stall_stage: default-width instance plus a 4-bit-counter
// instance sharing the same stimulus.
module tb_fetch_stall_stage;

    logic        clk;
    logic        reset;
    logic        PCwrite;
    logic        IFIDwrite;
    logic        controlmux;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [8:0]  id_ctrl;

    logic [31:0] pc, ifid_pc, ifid_instr;
    logic        ifid_valid, idex_valid;
    logic [8:0]  idex_ctrl;
    logic [15:0] stall_cycles, flush_cycles;

    logic [31:0] pc4, ifid_pc4, ifid_instr4;
    logic        ifid_valid4, idex_valid4;
    logic [8:0]  idex_ctrl4;
    logic [3:0]  stall_cycles4, flush_cycles4;

    fetch_stall_stage dut (
        .clk(clk), .reset(reset), .PCwrite(PCwrite), .IFIDwrite(IFIDwrite),
        .controlmux(controlmux), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .id_ctrl(id_ctrl),
        .pc(pc), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .idex_ctrl(idex_ctrl), .idex_valid(idex_valid),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    fetch_stall_stage #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .PCwrite(PCwrite), .IFIDwrite(IFIDwrite),
        .controlmux(controlmux), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instr(imem_instr), .id_ctrl(id_ctrl),
        .pc(pc4), .ifid_pc(ifid_pc4), .ifid_instr(ifid_instr4), .ifid_valid(ifid_valid4),
        .idex_ctrl(idex_ctrl4), .idex_valid(idex_valid4),
        .stall_cycles(stall_cycles4), .flush_cycles(flush_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pcw, ifw, cm, br;
        logic [31:0] tgt, ins;
        logic [8:0]  ctl;
        logic [31:0] e_pc, e_ipc, e_ins;
        logic        e_iv;
        logic [8:0]  e_ctl;
        logic        e_xv;
        logic [15:0] e_st, e_fl;
    } vec_t;

    localparam int unsigned NV = 18;
    vec_t vecs [NV];
    vec_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic pcw, input logic ifw, input logic cm,
                         input logic br, input logic [31:0] tgt, input logic [31:0] ins,
                         input logic [8:0] ctl);
        reset = rst; PCwrite = pcw; IFIDwrite = ifw; controlmux = cm;
        branch_taken = br; branch_target = tgt; imem_instr = ins; id_ctrl = ctl;
    endtask

    initial begin
        vec_t v, e;
        logic [31:0] I;
        logic [8:0]  C;
        I = 32'h20010005;
        C = 9'h1FF;
        //             rst   pcw   ifw   cm    br    tgt           ins           ctl      pc            ipc           ins           iv    ctl      xv    st     fl
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        I,            C,       32'h0,        32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        I,            C,       32'h0,        32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        I,            C,       32'h0,        32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        I,            C,       32'h4,        32'h0,        I,            1'b1, 9'h000, 1'b0, 16'd0, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        I,            C,       32'h8,        32'h4,        I,            1'b1, C,      1'b1, 16'd0, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        I,            C,       32'h8,        32'h4,        I,            1'b1, 9'h000, 1'b0, 16'd1, 16'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h11111111, 9'h0A5,  32'hC,        32'h8,        32'h11111111, 1'b1, 9'h0A5, 1'b1, 16'd1, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h43,       32'h11111111, C,       32'h40,       32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd1, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h22222222, C,       32'h44,       32'h40,       32'h22222222, 1'b1, 9'h000, 1'b0, 16'd1, 16'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h33333333, C,       32'h44,       32'h44,       32'h33333333, 1'b1, C,      1'b1, 16'd2, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h44444444, 9'h033,  32'h48,       32'h44,       32'h33333333, 1'b1, 9'h033, 1'b1, 16'd2, 16'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h44444444, C,       32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd2, 16'd2};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h55555555, C,       32'h0,        32'hFFFFFFFC, 32'h55555555, 1'b1, 9'h000, 1'b0, 16'd2, 16'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h66666666, 9'h100,  32'h4,        32'h0,        32'h66666666, 1'b1, 9'h100, 1'b1, 16'd2, 16'd2};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h80,       32'h66666666, C,       32'h80,       32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd2, 16'd3};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h77777777, C,       32'h80,       32'h80,       32'h77777777, 1'b1, 9'h000, 1'b0, 16'd3, 16'd3};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100,      32'h77777777, C,       32'h0,        32'h0,        32'h0,        1'b0, 9'h000, 1'b0, 16'd0, 16'd0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h88888888, 9'h155,  32'h4,        32'h0,        32'h88888888, 1'b1, 9'h000, 1'b0, 16'd0, 16'd0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 9'h0);

        for (int unsigned i = 0; i < NV; i++) begin
            @(negedge clk);
            v = vecs[i];
            drive(v.rst, v.pcw, v.ifw, v.cm, v.br, v.tgt, v.ins, v.ctl);
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty v%0d: got 0 entries expected 1", i);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d pc", i),         pc,                  e.e_pc);
                check($sformatf("v%0d ifid_pc", i),    ifid_pc,             e.e_ipc);
                check($sformatf("v%0d ifid_instr", i), ifid_instr,          e.e_ins);
                check($sformatf("v%0d ifid_valid", i), 32'(ifid_valid),     32'(e.e_iv));
                check($sformatf("v%0d idex_ctrl", i),  32'(idex_ctrl),      32'(e.e_ctl));
                check($sformatf("v%0d idex_valid", i), 32'(idex_valid),     32'(e.e_xv));
                check($sformatf("v%0d stall", i),      32'(stall_cycles),   32'(e.e_st));
                check($sformatf("v%0d flush", i),      32'(flush_cycles),   32'(e.e_fl));
                check($sformatf("v%0d stall4", i),     32'(stall_cycles4),  32'(e.e_st[3:0]));
            end
        end

        // Long stall: PC frozen, 4-bit counter pins at 4'hF, 16-bit counter keeps going.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h99999999, C);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d pc", k),     pc,                  32'h4);
            check($sformatf("hold%0d pc4", k),    pc4,                 32'h4);
            check($sformatf("hold%0d stall4", k), 32'(stall_cycles4),  (k < 15) ? k : 15);
        end
        check("hold stall16", 32'(stall_cycles), 32'd20);

        // Repeated redirects: flush counter saturation, stall counter untouched.
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h203, 32'hAAAAAAAA, C);
            @(posedge clk);
            #1;
            check($sformatf("flush%0d pc", k),     pc,                 32'h200);
            check($sformatf("flush%0d flush4", k), 32'(flush_cycles4), (k < 15) ? k : 15);
            check($sformatf("flush%0d stall4", k), 32'(stall_cycles4), 32'hF);
        end
        check("flush flush16", 32'(flush_cycles), 32'd18);
        check("flush stall16", 32'(stall_cycles), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
